// File: rtl/lc3b_types.sv
// Shared type definitions for the LC-3b memory datapath.
//
// Contents:
//   mem_op_t      memory operation carried from EX into MEM
//   isLoadOp      op returns data to WB (LDW, LDB, LDI)
//   isStoreOp     op writes memory (STW, STB, STI)
//   isIndirectOp  op fetches a pointer before the access (LDI, STI)
//   isByteOp      op touches a single byte lane (LDB, STB)
package lc3b_types;

    typedef enum logic [2:0] {
        NONE = 3'd0,
        LDW  = 3'd1,
        LDB  = 3'd2,
        STW  = 3'd3,
        STB  = 3'd4,
        LDI  = 3'd5,
        STI  = 3'd6
    } mem_op_t;

    function automatic logic isLoadOp(input mem_op_t op);
        return (op == LDW) || (op == LDB) || (op == LDI);
    endfunction

    function automatic logic isStoreOp(input mem_op_t op);
        return (op == STW) || (op == STB) || (op == STI);
    endfunction

    function automatic logic isIndirectOp(input mem_op_t op);
        return (op == LDI) || (op == STI);
    endfunction

    function automatic logic isByteOp(input mem_op_t op);
        return (op == LDB) || (op == STB);
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Byte-lane helper for the memory access unit.
//
// Ports:
//   lane       in   LANE_W   byte lane selected by the low address bits
//   rdataWord  in   DATA_W   full word returned by memory
//   storeByte  in   8        byte to be written by a byte store
//   loadByte   out  DATA_W   selected lane of rdataWord, zero-extended
//   storeWord  out  DATA_W   storeByte replicated into every lane
//   laneMask   out  LANES    one-hot write enable for the selected lane
module byte_lane_unit #(
    parameter int DATA_W = 16,
    localparam int LANES  = DATA_W / 8,
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic [LANE_W-1:0] lane,
    input  logic [DATA_W-1:0] rdataWord,
    input  logic [7:0]        storeByte,
    output logic [DATA_W-1:0] loadByte,
    output logic [DATA_W-1:0] storeWord,
    output logic [LANES-1:0]  laneMask
);

    always_comb begin
        loadByte  = DATA_W'(rdataWord[8*int'(lane) +: 8]);
        storeWord = {LANES{storeByte}};
        laneMask  = LANES'(1) << lane;
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: sequences direct and indirect loads/stores to a
// single-port memory with a completion handshake, stalling the pipeline
// until the access finishes.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   valid_in, op      MEM stage instruction valid and its memory op
//   addr_in, wdata_in effective byte address and store data from EX
//   mem_resp          memory completion strobe
//   mem_rdata         memory read data
//   mem_addr          memory address
//   mem_read          read request strobe
//   mem_write         write request strobe
//   mem_byte_enable   per-lane write mask (zero unless writing)
//   mem_wdata         memory write data
//   rdata_out         load result to WB, held until the next load
//   stall             freezes the upstream pipeline
//   done              one-cycle completion pulse
module mem_access_unit
    import lc3b_types::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    localparam int LANES  = DATA_W / 8,
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  mem_op_t           op,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic              mem_resp,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [LANES-1:0]  mem_byte_enable,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] rdata_out,
    output logic              stall,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, PTR, ACCESS, DONE} state_t;

    localparam logic [ADDR_W-1:0] LANE_BITS = ADDR_W'((1 << LANE_W) - 1);

    state_t            state, stateNext;
    mem_op_t           opQ;
    logic [ADDR_W-1:0] addrQ, ptrQ;
    logic [DATA_W-1:0] wdataQ;
    logic              accept, ptrLoad, resultLoad;
    logic [DATA_W-1:0] loadByte, storeWord;
    logic [LANES-1:0]  laneMask;

    function automatic logic [ADDR_W-1:0] alignDown(input logic [ADDR_W-1:0] a);
        return a & ~LANE_BITS;
    endfunction

    byte_lane_unit #(.DATA_W(DATA_W)) u_byteLanes (
        .lane      (addrQ[LANE_W-1:0]),
        .rdataWord (mem_rdata),
        .storeByte (wdataQ[7:0]),
        .loadByte  (loadByte),
        .storeWord (storeWord),
        .laneMask  (laneMask)
    );

    // Outputs depend only on state and latched registers; the live op,
    // address and data inputs are looked at solely when accepting in IDLE.
    always_comb begin
        stateNext       = state;
        mem_addr        = '0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = '0;
        mem_wdata       = '0;
        stall           = 1'b0;
        done            = 1'b0;
        accept          = 1'b0;
        ptrLoad         = 1'b0;
        resultLoad      = 1'b0;
        case (state)
            IDLE: begin
                if (valid_in && op != NONE) begin
                    accept    = 1'b1;
                    stall     = 1'b1;
                    stateNext = isIndirectOp(op) ? PTR : ACCESS;
                end
            end
            PTR: begin
                stall    = 1'b1;
                mem_read = 1'b1;
                mem_addr = alignDown(addrQ);
                if (mem_resp) begin
                    ptrLoad   = 1'b1;
                    stateNext = ACCESS;
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (isByteOp(opQ))
                    mem_addr = addrQ;
                else
                    mem_addr = alignDown(isIndirectOp(opQ) ? ptrQ : addrQ);
                mem_read  = isLoadOp(opQ);
                mem_write = isStoreOp(opQ);
                if (isStoreOp(opQ)) begin
                    mem_byte_enable = isByteOp(opQ) ? laneMask : '1;
                    mem_wdata       = isByteOp(opQ) ? storeWord : wdataQ;
                end
                if (mem_resp) begin
                    resultLoad = isLoadOp(opQ);
                    stateNext  = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        // Reset is synchronous, so the state register may still hold a busy
        // state during the reset cycle; silence every request immediately.
        if (reset) begin
            stateNext       = IDLE;
            mem_addr        = '0;
            mem_read        = 1'b0;
            mem_write       = 1'b0;
            mem_byte_enable = '0;
            mem_wdata       = '0;
            stall           = 1'b0;
            done            = 1'b0;
            accept          = 1'b0;
            ptrLoad         = 1'b0;
            resultLoad      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            opQ       <= NONE;
            addrQ     <= '0;
            wdataQ    <= '0;
            ptrQ      <= '0;
            rdata_out <= '0;
        end else begin
            state <= stateNext;
            if (accept) begin
                opQ    <= op;
                addrQ  <= addr_in;
                wdataQ <= wdata_in;
            end
            if (ptrLoad)
                ptrQ <= ADDR_W'(mem_rdata);
            if (resultLoad)
                rdata_out <= isByteOp(opQ) ? loadByte : mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    import lc3b_types::*;

    logic        clk;
    logic        reset;

    // 16-bit instance
    logic        valid_in;
    mem_op_t     op;
    logic [15:0] addr_in;
    logic [15:0] wdata_in;
    logic        mem_resp;
    logic [15:0] mem_rdata;
    logic [15:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_wdata;
    logic [15:0] rdata_out;
    logic        stall;
    logic        done;

    // 32-bit instance
    logic        valid32;
    mem_op_t     op32;
    logic [15:0] addr32;
    logic [31:0] wdata32;
    logic        resp32;
    logic [31:0] rdataIn32;
    logic [15:0] memAddr32;
    logic        read32;
    logic        write32;
    logic [3:0]  be32;
    logic [31:0] memWdata32;
    logic [31:0] rdataOut32;
    logic        stall32;
    logic        done32;

    int passCnt = 0;
    int totalCnt = 0;
    int stallCnt;
    logic bothHigh = 1'b0;

    mem_access_unit #(.DATA_W(16), .ADDR_W(16)) dut16 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .op(op),
        .addr_in(addr_in), .wdata_in(wdata_in), .mem_resp(mem_resp),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_read(mem_read),
        .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
        .mem_wdata(mem_wdata), .rdata_out(rdata_out), .stall(stall), .done(done)
    );

    mem_access_unit #(.DATA_W(32), .ADDR_W(16)) dut32 (
        .clk(clk), .reset(reset), .valid_in(valid32), .op(op32),
        .addr_in(addr32), .wdata_in(wdata32), .mem_resp(resp32),
        .mem_rdata(rdataIn32), .mem_addr(memAddr32), .mem_read(read32),
        .mem_write(write32), .mem_byte_enable(be32),
        .mem_wdata(memWdata32), .rdata_out(rdataOut32), .stall(stall32), .done(done32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ((mem_read && mem_write) || (read32 && write32))
            bothHigh = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        reset = 1'b1;
        valid_in = 1'b1; op = LDW; addr_in = 16'h1111; wdata_in = 16'h0;
        mem_resp = 1'b1; mem_rdata = 16'hFFFF;
        valid32 = 1'b0; op32 = NONE; addr32 = 16'h0; wdata32 = 32'h0;
        resp32 = 1'b0; rdataIn32 = 32'h0;
        tick();
        tick();
        // Outputs during reset, even with a valid op presented
        chk("rst_read",  mem_read, 0);
        chk("rst_write", mem_write, 0);
        chk("rst_stall", stall, 0);
        chk("rst_done",  done, 0);
        chk("rst_be",    mem_byte_enable, 0);
        chk("rst_rdata", rdata_out, 0);
        reset = 1'b0; valid_in = 1'b0; op = NONE; mem_resp = 1'b0;
        tick();
        chk("idle_stall", stall, 0);

        // LDW 0x3001, zero-wait, 0xBEEF
        valid_in = 1'b1; op = LDW; addr_in = 16'h3001;
        #1;
        chk("ldw_issue_stall", stall, 1);
        chk("ldw_issue_read", mem_read, 0);
        tick();
        valid_in = 1'b0; op = STW; addr_in = 16'hDEAD; // ignored while busy
        mem_resp = 1'b1; mem_rdata = 16'hBEEF;
        #1;
        chk("ldw_addr", mem_addr, 16'h3000);
        chk("ldw_read", mem_read, 1);
        chk("ldw_write", mem_write, 0);
        tick();
        mem_resp = 1'b0; mem_rdata = 16'h0;
        #1;
        chk("ldw_done_c2", done, 1);
        chk("ldw_done_stall", stall, 0);
        chk("ldw_rdata", rdata_out, 16'hBEEF);
        tick();
        op = NONE;
        #1;
        chk("ldw_done_pulse", done, 0);

        // STB 0x4001, wdata 0x12AB, 3 wait cycles
        valid_in = 1'b1; op = STB; addr_in = 16'h4001; wdata_in = 16'h12AB;
        tick();
        valid_in = 1'b0; wdata_in = 16'h0;
        stallCnt = 0;
        for (int i = 0; i < 4; i++) begin
            mem_resp = (i == 3);
            #1;
            if (stall) stallCnt++;
            if (i == 0) begin
                chk("stb_be", mem_byte_enable, 2'b10);
                chk("stb_wdata", mem_wdata, 16'hABAB);
                chk("stb_addr", mem_addr, 16'h4001);
                chk("stb_write", mem_write, 1);
                chk("stb_read", mem_read, 0);
            end
            tick();
        end
        mem_resp = 1'b0;
        #1;
        chk("stb_stall_cycles", stallCnt, 4);
        chk("stb_done", done, 1);
        chk("stb_keeps_rdata", rdata_out, 16'hBEEF);
        chk("stb_be_idle", mem_byte_enable, 0);
        tick();

        // LDI 0x5000 -> pointer 0x6002 -> 0x0077 (one pointer wait)
        valid_in = 1'b1; op = LDI; addr_in = 16'h5000;
        tick();
        valid_in = 1'b0; op = NONE;
        #1;
        chk("ldi_ptr_addr", mem_addr, 16'h5000);
        chk("ldi_ptr_read", mem_read, 1);
        tick();
        mem_resp = 1'b1; mem_rdata = 16'h6002;
        tick();
        mem_rdata = 16'h0077;
        #1;
        chk("ldi_addr2", mem_addr, 16'h6002);
        chk("ldi_read2", mem_read, 1);
        tick();
        mem_resp = 1'b0; mem_rdata = 16'h0;
        #1;
        chk("ldi_done", done, 1);
        chk("ldi_rdata", rdata_out, 16'h0077);
        tick();

        // Reset during PTR wait, late mem_resp
        valid_in = 1'b1; op = LDI; addr_in = 16'h5000;
        tick();
        valid_in = 1'b0; op = NONE;
        tick();
        reset = 1'b1;
        #1;
        chk("rstptr_read_in_rst", mem_read, 0);
        chk("rstptr_stall_in_rst", stall, 0);
        tick();
        reset = 1'b0; mem_resp = 1'b1; mem_rdata = 16'h6002;
        #1;
        chk("rstptr_read", mem_read, 0);
        chk("rstptr_stall", stall, 0);
        tick();
        mem_resp = 1'b0;
        #1;
        chk("rstptr_done", done, 0);
        chk("rstptr_idle_read", mem_read, 0);
        chk("rstptr_rdata", rdata_out, 0);

        // STI then LDW back-to-back
        valid_in = 1'b1; op = STI; addr_in = 16'h2000; wdata_in = 16'h5A5A;
        tick();
        valid_in = 1'b0; op = NONE;
        mem_resp = 1'b1; mem_rdata = 16'h1234;
        tick();
        mem_rdata = 16'h0;
        #1;
        chk("sti_addr", mem_addr, 16'h1234);
        chk("sti_write", mem_write, 1);
        chk("sti_be", mem_byte_enable, 2'b11);
        chk("sti_wdata", mem_wdata, 16'h5A5A);
        tick();
        mem_resp = 1'b0;
        valid_in = 1'b1; op = LDW; addr_in = 16'h3002;
        #1;
        chk("b2b_done", done, 1);
        chk("b2b_done_stall", stall, 0);
        tick();
        #1;
        chk("b2b_bubble_stall", stall, 1);
        chk("b2b_bubble_read", mem_read, 0);
        chk("b2b_bubble_write", mem_write, 0);
        tick();
        valid_in = 1'b0; op = NONE;
        mem_resp = 1'b1; mem_rdata = 16'hCAFE;
        #1;
        chk("b2b_ldw_read", mem_read, 1);
        chk("b2b_ldw_addr", mem_addr, 16'h3002);
        tick();
        mem_resp = 1'b0;
        #1;
        chk("b2b_ldw_rdata", rdata_out, 16'hCAFE);
        tick();

        // LDB 0x7003 on 32-bit word 0x11223344
        valid32 = 1'b1; op32 = LDB; addr32 = 16'h7003;
        tick();
        valid32 = 1'b0; op32 = NONE;
        resp32 = 1'b1; rdataIn32 = 32'h11223344;
        #1;
        chk("ldb32_addr", memAddr32, 16'h7003);
        chk("ldb32_read", read32, 1);
        tick();
        resp32 = 1'b0; rdataIn32 = 32'h0;
        #1;
        chk("ldb32_done", done32, 1);
        chk("ldb32_rdata", rdataOut32, 32'h00000011);
        tick();

        chk("never_read_and_write", bothHigh, 0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
